imm_decode_stage: RTL

Registered decode stage for the pipelined RISC-V core, between fetch and execute. It accepts instruction/PC pairs over a valid/ready handshake and classifies each opcode into an immediate-format select code. It registers the assembled 32-bit immediate alongside the instruction. A two-entry skid buffer lets upstream ready be a pure flop output; a flush input discards all buffered work.

---
 rtl/imm_decode_stage_if.sv | 47 ++++
 rtl/imm_decode_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage_if.sv
// ---------------------------------------------------------------------------
// imm_decode_stage_if
// Handshake and data bundle between fetch, the decode stage and execute.
//
// Upstream (fetch -> decode):
//   in_valid    fetch presents an instruction
//   in_ready    decode can accept (registered in the stage)
//   in_instr    raw 32-bit instruction word
//   in_pc       PC of in_instr
// Downstream (decode -> execute):
//   out_valid   head entry valid
//   out_ready   execute consumes the head entry
//   out_instr   head instruction
//   out_pc      head PC
//   out_sel_imm immediate format code of the head entry
//   out_imm     assembled immediate of the head entry
//   out_illegal head opcode unrecognised
//
// Modports:
//   slave  - the decode stage itself
//   master - the surrounding pipeline (fetch driver plus execute consumer)
// ---------------------------------------------------------------------------
interface imm_decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  out_sel_imm;
  logic [31:0] out_imm;
  logic        out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_sel_imm, out_imm,
           out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_sel_imm, out_imm,
           out_illegal
  );
endinterface

// File: rtl/imm_decode_stage.sv
// ---------------------------------------------------------------------------
// imm_decode_stage
// Registered RV32 decode stage between fetch and execute. Each accepted
// instruction is classified into an immediate-format select code and its
// 32-bit immediate is assembled and stored with the instruction and PC.
// A two-entry buffer (head H plus skid K) lets in_ready be a pure flop.
//
// Ports:
//   clk_i   single clock, rising edge
//   rst_i   synchronous active-high reset
//   flush_i discard all held entries and any entry offered this cycle
//   bus     imm_decode_stage_if.slave (in_* / out_* handshake and data)
//
// Select codes: 000 U, 001 J, 010 I, 011 B, 100 S, 101 shamt, 110 none,
// 111 unrecognised.
//
// Build option: IMM_ILLEGAL_CHK_EN
//   defined   - unrecognised opcodes and OP-IMM shifts with a bad funct7
//               give sel 111, imm 0 and out_illegal = 1
//   undefined - out_illegal is tied 0; unrecognised opcodes fall back to the
//               U format and bad-funct7 shifts are treated as I format
// ---------------------------------------------------------------------------
module imm_decode_stage (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  imm_decode_stage_if.slave  bus
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  localparam logic [2:0] SelU     = 3'b000;
  localparam logic [2:0] SelJ     = 3'b001;
  localparam logic [2:0] SelI     = 3'b010;
  localparam logic [2:0] SelB     = 3'b011;
  localparam logic [2:0] SelS     = 3'b100;
  localparam logic [2:0] SelShamt = 3'b101;
  localparam logic [2:0] SelNone  = 3'b110;
`ifdef IMM_ILLEGAL_CHK_EN
  localparam logic [2:0] SelIll   = 3'b111;
`endif

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  sel;
    logic [31:0] imm;
`ifdef IMM_ILLEGAL_CHK_EN
    logic        illegal;
`endif
  } entry_t;

  state_e state_q, state_d;
  logic   inReady_q;
  entry_t head_q;
  entry_t skid_q;
  entry_t newEntry;
  logic   push;
  logic   pop;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        isShift;
  logic        goodFunct7;
  logic [31:0] immU;
  logic [31:0] immJ;
  logic [31:0] immI;
  logic [31:0] immB;
  logic [31:0] immS;
  logic [31:0] immShamt;

  assign opcode     = bus.in_instr[6:0];
  assign funct3     = bus.in_instr[14:12];
  assign funct7     = bus.in_instr[31:25];
  assign isShift    = (funct3 == 3'b001) || (funct3 == 3'b101);
  // SRAI is the only shift that sets a funct7 bit.
  assign goodFunct7 = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);

  assign immU     = {bus.in_instr[31:12], 12'b0};
  assign immJ     = {{12{bus.in_instr[31]}}, bus.in_instr[19:12],
                     bus.in_instr[20], bus.in_instr[30:21], 1'b0};
  assign immI     = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
  assign immB     = {{20{bus.in_instr[31]}}, bus.in_instr[7],
                     bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
  assign immS     = {{20{bus.in_instr[31]}}, bus.in_instr[31:25],
                     bus.in_instr[11:7]};
  assign immShamt = {27'b0, bus.in_instr[24:20]};

  // Combinational classification of the offered instruction into the entry
  // that will be written if the push happens this cycle.
  always_comb begin
    newEntry       = '0;
    newEntry.instr = bus.in_instr;
    newEntry.pc    = bus.in_pc;
    newEntry.sel   = SelNone;
    newEntry.imm   = '0;
    unique case (opcode)
      OpLui, OpAuipc: begin
        newEntry.sel = SelU;
        newEntry.imm = immU;
      end
      OpJal: begin
        newEntry.sel = SelJ;
        newEntry.imm = immJ;
      end
      OpJalr, OpLoad: begin
        newEntry.sel = SelI;
        newEntry.imm = immI;
      end
      OpBranch: begin
        newEntry.sel = SelB;
        newEntry.imm = immB;
      end
      OpStore: begin
        newEntry.sel = SelS;
        newEntry.imm = immS;
      end
      OpImm: begin
        if (isShift && goodFunct7) begin
          newEntry.sel = SelShamt;
          newEntry.imm = immShamt;
        end else if (isShift) begin
`ifdef IMM_ILLEGAL_CHK_EN
          newEntry.sel     = SelIll;
          newEntry.illegal = 1'b1;
`else
          newEntry.sel = SelI;
          newEntry.imm = immI;
`endif
        end else begin
          newEntry.sel = SelI;
          newEntry.imm = immI;
        end
      end
      OpReg: begin
        newEntry.sel = SelNone;
      end
      default: begin
`ifdef IMM_ILLEGAL_CHK_EN
        newEntry.sel     = SelIll;
        newEntry.illegal = 1'b1;
`else
        newEntry.sel = SelU;
        newEntry.imm = immU;
`endif
      end
    endcase
  end

  assign push = bus.in_valid & inReady_q;
  assign pop  = (state_q != EMPTY) & bus.out_ready;

  // Occupancy next state; flush empties the buffer whatever else happens.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = TWO;
        else if (!push && pop) state_d = EMPTY;
      end
      TWO:     if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
    if (flush_i) state_d = EMPTY;
  end

  // State, registered in_ready and the two entry registers. While TWO the
  // skid holds the younger entry and moves into the head on a pop. Data
  // writes are skipped on flush since nothing survives it anyway.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= EMPTY;
      inReady_q  <= 1'b1;
      head_q     <= '0;
      head_q.sel <= SelNone;
      skid_q     <= '0;
      skid_q.sel <= SelNone;
    end else begin
      state_q   <= state_d;
      inReady_q <= (state_d != TWO);
      if (!flush_i) begin
        unique case (state_q)
          EMPTY: if (push) head_q <= newEntry;
          ONE: begin
            if (push && pop) head_q <= newEntry;
            else if (push)   skid_q <= newEntry;
          end
          TWO:     if (pop) head_q <= skid_q;
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready    = inReady_q;
  assign bus.out_valid   = (state_q != EMPTY);
  assign bus.out_instr   = head_q.instr;
  assign bus.out_pc      = head_q.pc;
  assign bus.out_sel_imm = head_q.sel;
  assign bus.out_imm     = head_q.imm;
`ifdef IMM_ILLEGAL_CHK_EN
  assign bus.out_illegal = head_q.illegal;
`else
  assign bus.out_illegal = 1'b0;
`endif

endmodule
